// File: rtl/vpu_wb_buf_unit.sv
// Lane write-back buffer: assembles lane results into SRAM lines, queues them
// in a small FIFO and streams them to the SRAM write port for one command.
module vpu_wb_buf_unit #(
  parameter int unsigned LANE_W     = 32,
  parameter int unsigned LANE_CNT   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          dst_addr_i,
  input  logic [CNT_W-1:0]           line_cnt_i,
  output logic                       done_o,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic                       is_reduction_i,
  input  logic [LANE_W-1:0]          wb_data_i,
  output logic                       dst_req_o,
  input  logic                       dst_ack_i,
  output logic                       dst_web_o,
  output logic                       dst_wlast_o,
  output logic [ADDR_W-1:0]          dst_addr_o,
  output logic [LANE_CNT*LANE_W-1:0] dst_wdata_o
);

  localparam int unsigned LINE_W = LANE_CNT * LANE_W;
  localparam int unsigned IDX_W  = (LANE_CNT > 1) ? $clog2(LANE_CNT) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    pushed_q;
  logic [IDX_W-1:0]    lane_idx_q;
  logic [LINE_W-1:0]   asm_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;

  logic [LINE_W-1:0]   mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
  logic                mem_last [FIFO_DEPTH];

  logic                start_acc, fifo_full, completes, beat, push, pop, last_line;
  logic [LINE_W-1:0]   line_data;
  logic [ADDR_W-1:0]   push_addr;

  assign start_acc = (state_q == S_IDLE) && start_i && (line_cnt_i != '0);
  assign fifo_full = (occ_q == OCC_W'(FIFO_DEPTH));
  assign completes = is_reduction_i || (lane_idx_q == IDX_W'(LANE_CNT - 1));
  assign wb_ready_o = (state_q == S_ACTIVE) && !(fifo_full && completes);
  assign beat      = wb_valid_i && wb_ready_o;
  assign push      = beat && completes;
  assign pop       = dst_req_o && dst_ack_i;
  assign last_line = (pushed_q == cnt_q - CNT_W'(1));
  assign push_addr = base_q + ADDR_W'(pushed_q);

  // Line image after this beat: broadcast in reduction mode, else one lane patched in.
  always_comb begin
    line_data = asm_q;
    if (is_reduction_i) begin
      line_data = {LANE_CNT{wb_data_i}};
    end else begin
      for (int unsigned k = 0; k < LANE_CNT; k++) begin
        if (lane_idx_q == IDX_W'(k)) line_data[k*LANE_W +: LANE_W] = wb_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_acc) state_d = S_ACTIVE;
      S_ACTIVE: if (push && last_line) state_d = S_DRAIN;
      S_DRAIN:  if (pop && mem_last[rd_ptr_q]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      cnt_q      <= '0;
      pushed_q   <= '0;
      lane_idx_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      if (start_acc) begin
        base_q     <= dst_addr_i;
        cnt_q      <= line_cnt_i;
        pushed_q   <= '0;
        lane_idx_q <= '0;
        asm_q      <= '0;
      end
      if (beat) begin
        asm_q      <= line_data;
        lane_idx_q <= completes ? '0 : lane_idx_q + IDX_W'(1);
      end
      if (push) begin
        pushed_q <= pushed_q + CNT_W'(1);
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage needs no reset; the read side is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_data[wr_ptr_q] <= line_data;
      mem_addr[wr_ptr_q] <= push_addr;
      mem_last[wr_ptr_q] <= last_line;
    end
  end

  assign done_o      = (state_q == S_IDLE);
  assign dst_req_o   = (occ_q != '0);
  assign dst_web_o   = !dst_req_o;
  assign dst_wlast_o = dst_req_o && mem_last[rd_ptr_q];
  assign dst_addr_o  = dst_req_o ? mem_addr[rd_ptr_q] : '0;
  assign dst_wdata_o = dst_req_o ? mem_data[rd_ptr_q] : '0;

endmodule
